// File: rtl/majority_voter_pkg.sv
// rtl/majority_voter_pkg.sv - shared types, defaults and helpers for majority_voter_seq
//
// Purpose : per-channel state enum, default parameter values and the
//           popcount helper used to form vote thresholds.
// Ports   : none (package)
// Options : MAJORITY_VOTER_SEQ_MASK_EN is consumed by majority_voter_seq.
package majority_voter_pkg;

  typedef enum logic [1:0] {
    CH_OK      = 2'd0,
    CH_SUSPECT = 2'd1,
    CH_FAULT   = 2'd2
  } chan_state_e;

  localparam int DEF_N      = 3;
  localparam int DEF_W      = 8;
  localparam int DEF_THRESH = 3;
  localparam int DEF_CNT_W  = 4;

  // Channel count is at most 15, so a 16-bit vector and 5-bit count suffice.
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/majority_voter_chan_mon.sv
// rtl/majority_voter_chan_mon.sv - per-channel consecutive-mismatch tracker
//
// Purpose : tracks OK / SUSPECT / FAULT for one channel. A run of THRESH
//           consecutive mismatching samples makes the channel sticky-faulted;
//           a clean sample returns it to OK. clr wins over any update.
// Ports   : clk          in  clock, rising edge
//           rst          in  synchronous active-high reset
//           sample_valid in  a sample is being voted this cycle
//           mism         in  this channel disagrees with the new vote
//           clr          in  return to OK with counter cleared
//           fault        out registered sticky fault flag
// Options : none
module majority_voter_chan_mon
  import majority_voter_pkg::*;
#(
  parameter int THRESH = DEF_THRESH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  logic mism,
  input  logic clr,
  output logic fault
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = CH_OK;
      cnt_d   = '0;
    end else if (sample_valid && (state_q != CH_FAULT)) begin
      if (mism) begin
        // Outside FAULT the counter is below THRESH, so +1 cannot overflow.
        if ((cnt_q + 1'b1) >= CNT_W'(THRESH)) begin
          state_d = CH_FAULT;
          cnt_d   = CNT_W'(THRESH);
        end else begin
          state_d = CH_SUSPECT;
          cnt_d   = cnt_q + 1'b1;
        end
      end else begin
        state_d = CH_OK;
        cnt_d   = '0;
      end
    end
    fault_d = (state_d == CH_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_OK;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/majority_voter_seq.sv
// rtl/majority_voter_seq.sv - registered N-way bitwise majority voter with fault tracking
//
// Purpose : votes N replicated W-bit words into one registered word, reports
//           which channels disagreed, and keeps sticky per-channel faults.
// Ports   : clk, rst (sync active-high), in_valid, din[N*W] (channel k at
//           [k*W +: W]), clr_fault -> out_valid, dout[W], mismatch[N],
//           fault[N], all_fault
// Options : MAJORITY_VOTER_SEQ_MASK_EN - faulted channels leave the vote,
//           ties hold the previous dout bit, all_fault reports total loss.
module majority_voter_seq
  import majority_voter_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int THRESH = DEF_THRESH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] din,
  input  logic           clr_fault,
  output logic           out_valid,
  output logic [W-1:0]   dout,
  output logic [N-1:0]   mismatch,
  output logic [N-1:0]   fault,
  output logic           all_fault
);

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   dout_q, dout_d;
  logic [N-1:0]   mismatch_q, mismatch_d;
  logic [N-1:0]   fault_w;
  logic [N-1:0]   part_mask;
  logic [4:0]     part_cnt;
  logic [W-1:0]   vote;

  // Mask uses the registered fault flags, so a channel that faults on this
  // edge is excluded starting with the next sample.
`ifdef MAJORITY_VOTER_SEQ_MASK_EN
  assign part_mask = ~fault_w;
  assign all_fault = &fault_w;
`else
  assign part_mask = '1;
  assign all_fault = 1'b0;
`endif

  assign part_cnt = popcount({{(16-N){1'b0}}, part_mask});

  always_comb begin
    logic [15:0] col;
    logic [4:0]  ones;
    col  = '0;
    ones = '0;
    vote = '0;
    for (int b = 0; b < W; b++) begin
      col = '0;
      for (int k = 0; k < N; k++) begin
        col[k] = din[k*W + b] & part_mask[k];
      end
      ones = popcount(col);
      // Compare 2*ones with the participant count to avoid a division.
      if ({ones, 1'b0} > {1'b0, part_cnt}) begin
        vote[b] = 1'b1;
      end else if ({ones, 1'b0} == {1'b0, part_cnt}) begin
        vote[b] = dout_q[b];  // tie: only reachable when channels are masked
      end else begin
        vote[b] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d = in_valid;
    dout_d      = dout_q;
    mismatch_d  = mismatch_q;
    if (in_valid) begin
      dout_d = vote;
      for (int k = 0; k < N; k++) begin
        // With no participants the vote is a frozen word, not a reference.
        mismatch_d[k] = (din[k*W +: W] != vote) && (part_cnt != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      mismatch_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      mismatch_q  <= mismatch_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_mon
    majority_voter_chan_mon #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
    ) u_mon (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (in_valid),
      .mism         (mismatch_d[k]),
      .clr          (clr_fault),
      .fault        (fault_w[k])
    );
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign mismatch  = mismatch_q;
  assign fault     = fault_w;

endmodule

// File: doc/majority_voter_seq.md
# majority_voter_seq

Registered, parametrised N-way bitwise majority voter with per-channel disagreement tracking and sticky fault flags, for redundant (TMR/NMR) datapaths. It sits after replicated logic copies and feeds one voted word downstream each valid cycle. Channels that repeatedly disagree with the vote are flagged for the system. Optionally, flagged channels are excluded from later votes.

## Interface
Parameters:
- N, 3, channel count; odd, 3..15
- W, 8, data width per channel
- THRESH, 3, consecutive mismatches that set a fault; 1..2^CNT_W-1
- CNT_W, 4, width of the per-channel mismatch counter

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  din holds a sample this cycle
- din  in  N*W  channel k occupies bits [k*W +: W]
- clr_fault  in  1  clears all fault flags and counters; one-cycle pulse
- out_valid  out  1  dout and mismatch are valid
- dout  out  W  voted word
- mismatch  out  N  bit k set if channel k differed from dout in any bit
- fault  out  N  sticky per-channel fault flag
- all_fault  out  1  every channel is faulted (only with mask feature)

## Operation
- Vote, per bit b: `dout[b] = 1` when the count of participating channels with bit b = 1 is greater than half of the participating count.
- Without masking, all N channels participate. N is odd, so ties cannot occur.
- Mismatch is computed against the new vote for the same sample.
- Per-channel states: OK (counter = 0), SUSPECT (0 < counter < THRESH), FAULT (sticky).
- On each in_valid sample, for a channel not in FAULT:
  - mismatch: counter += 1, saturating at THRESH. Reaching THRESH enters FAULT and sets `fault[k]`.
  - clean: counter = 0, channel returns to OK.
- In FAULT, the counter is frozen and `mismatch[k]` still reports.
- clr_fault returns all channels to OK with counters at 0.
- clr_fault wins over a simultaneous mismatch or threshold crossing; that sample updates no counter.
- in_valid low: outputs other than out_valid hold, counters hold, and out_valid = 0 next cycle.

## Timing
- Latency is 1 cycle: a sample with in_valid high at edge t produces out_valid/dout/mismatch after edge t+1.
- fault[k] rises at the same edge as the mismatch output of the THRESH-th consecutive mismatch.
- Reset values: out_valid 0, dout 0, mismatch 0, fault 0, all_fault 0, all counters 0.
- Reset dominates in_valid and clr_fault.
- Reset mid-stream discards the in-flight sample; out_valid is 0 the cycle after reset deasserts.
- Back-to-back valid samples give full throughput, one word per cycle, with no stalls.

## Configuration
- MAJORITY_VOTER_SEQ_MASK_EN defined:
  - Channels with fault set are excluded from the vote.
  - Participating count is N minus the number of faults.
  - A tie on bit b holds the previous dout[b].
  - If all channels are faulted, dout holds, mismatch = 0, and all_fault = 1.
  - The mask uses the fault register value from before the edge, so a newly faulted channel is excluded from the next sample onward.
- Macro undefined:
  - All N channels always vote.
  - all_fault is tied to 0.
  - fault is informational only.

## Structure
- Shared package majority_voter_pkg holds:
  - the per-channel state enum (OK, SUSPECT, FAULT)
  - default parameter constants
  - a popcount function used for the vote threshold
- One sub-module, majority_voter_chan_mon: a single channel's counter/state machine, instantiated N times via generate.
- The vote logic stays in the top module.

## Test plan
All scenarios use N=3, W=8, THRESH=3.
- Unanimous: din = {0xA5,0xA5,0xA5}, in_valid=1 -> next cycle dout=0xA5, mismatch=000, fault=000.
- Single outlier: ch2=0xFF, ch1=ch0=0x00 -> dout=0x00, mismatch=100. After the 3rd consecutive sample, fault=100 on that same output cycle.
- Intermittent: ch0 mismatches twice, then is clean, then mismatches twice -> fault stays 000 because the counter reset on the clean sample.
- Clear race: clr_fault asserted together with the 3rd mismatch of ch1 -> fault=000 and counter 0; two further mismatches keep fault=000.
- Mask (macro on): after ch2 faults, ch0=0x0F, ch1=0xF0, ch2=0xFF -> tie on every bit, dout holds its previous value. After all channels fault -> all_fault=1, dout frozen.
- Reset mid-stream: rst pulsed while in_valid streams -> all outputs and counters 0, out_valid=0 for the cycle after rst falls, and voting resumes with 1-cycle latency.
